// File: rtl/mem_access_unit.sv
// Memory access unit: accepts one load/store from the pipeline, runs it over a
// req/ack data-memory bus with optional timeout, steers store byte lanes and
// rotates/extends load data for writeback.

package mem_access_unit_pkg;

    // Request as latched from the pipeline at accept time
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic        byte_acc;
        logic        sgn;
        logic [31:0] wdata;
    } mau_req_t;

    // Word-wide bus payload presented while the request is outstanding
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mau_bus_t;

endpackage

module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_CNT_W       = 8
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic [31:0] addr_in,
    input  logic        wr_en_in,
    input  logic        byte_en_in,
    input  logic        signed_in,
    input  logic [31:0] wdata_in,
    output logic        mem_req_out,
    output logic        mem_we_out,
    output logic [31:0] mem_addr_out,
    output logic [3:0]  mem_be_out,
    output logic [31:0] mem_wdata_out,
    input  logic [31:0] mem_rdata_in,
    input  logic        mem_ack_in,
    output logic        done_out,
    output logic        rd_valid_out,
    output logic [31:0] rd_data_out,
    output logic        busy_out,
    output logic        timeout_err_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
    mau_req_t            lat_q, lat_d;
    mau_req_t            in_req;
    mau_bus_t            bus_d;
    logic                timeout_hit;

    logic        ready_d;
    logic        req_d;
    logic        done_d;
    logic        rd_valid_d;
    logic        err_d;
    logic [31:0] rd_data_d;

    // Bus fields derived from a request: aligned address, lane enables, replicated byte data
    function automatic mau_bus_t bus_fields(input mau_req_t r);
        mau_bus_t b;
        b.we    = r.we;
        b.addr  = {r.addr[31:2], 2'b00};
        b.be    = 4'b1111;
        b.wdata = '0;
        if (r.we) begin
            if (r.byte_acc) begin
                b.be    = 4'b0001 << r.addr[1:0];
                b.wdata = {4{r.wdata[7:0]}};
            end else begin
                b.wdata = r.wdata;
            end
        end
        return b;
    endfunction

    // Load writeback value: word rotated so the addressed byte lands in [7:0], or one lane extended
    function automatic logic [31:0] load_result(input mau_req_t r, input logic [31:0] rdata);
        logic [31:0] rot;
        logic [31:0] res;
        rot = 32'({rdata, rdata} >> {r.addr[1:0], 3'b000});
        if (r.byte_acc) begin
            res = {{24{r.sgn & rot[7]}}, rot[7:0]};
        end else begin
            res = rot;
        end
        return res;
    endfunction

    // Incoming pipeline request
    always_comb begin
        in_req.addr     = addr_in;
        in_req.we       = wr_en_in;
        in_req.byte_acc = byte_en_in;
        in_req.sgn      = signed_in;
        in_req.wdata    = wdata_in;
    end

    // Abort once the counter is about to reach the limit without an ack; zero disables it
    always_comb begin
        timeout_hit = (TIMEOUT_CYCLES != 0) &&
                      (cnt_q == TO_CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Next-state and next-output logic; outputs are registered from these values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        bus_d      = '0;
        ready_d    = 1'b0;
        req_d      = 1'b0;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        rd_data_d  = rd_data_out;

        case (state_q)
            IDLE: begin
                if (req_valid_in) begin
                    lat_d   = in_req;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    bus_d   = bus_fields(in_req);
                    state_d = REQ;
                end else begin
                    ready_d = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack_in) begin
                    cnt_d      = '0;
                    done_d     = 1'b1;
                    rd_valid_d = ~lat_q.we;
                    if (!lat_q.we) begin
                        rd_data_d = load_result(lat_q, mem_rdata_in);
                    end
                    state_d    = RESP;
                end else if (timeout_hit) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + TO_CNT_W'(1);
                    req_d   = 1'b1;
                    bus_d   = bus_fields(lat_q);
                end
            end
            RESP: begin
                cnt_d   = '0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs; synchronous active-low reset
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            lat_q           <= '0;
            req_ready_out   <= 1'b1;
            busy_out        <= 1'b0;
            mem_req_out     <= 1'b0;
            mem_we_out      <= 1'b0;
            mem_addr_out    <= '0;
            mem_be_out      <= '0;
            mem_wdata_out   <= '0;
            done_out        <= 1'b0;
            rd_valid_out    <= 1'b0;
            rd_data_out     <= '0;
            timeout_err_out <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            lat_q           <= lat_d;
            req_ready_out   <= ready_d;
            busy_out        <= ~ready_d;
            mem_req_out     <= req_d;
            mem_we_out      <= bus_d.we;
            mem_addr_out    <= bus_d.addr;
            mem_be_out      <= bus_d.be;
            mem_wdata_out   <= bus_d.wdata;
            done_out        <= done_d;
            rd_valid_out    <= rd_valid_d;
            rd_data_out     <= rd_data_d;
            timeout_err_out <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset abort
// sequence, and randomized transactions against a byte-level reference model.
module tb_mem_access_unit;

    localparam int unsigned TO = 4;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        req_valid_in;
    logic        req_ready_out;
    logic [31:0] addr_in;
    logic        wr_en_in;
    logic        byte_en_in;
    logic        signed_in;
    logic [31:0] wdata_in;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [3:0]  mem_be_out;
    logic [31:0] mem_wdata_out;
    logic [31:0] mem_rdata_in;
    logic        mem_ack_in;
    logic        done_out;
    logic        rd_valid_out;
    logic [31:0] rd_data_out;
    logic        busy_out;
    logic        timeout_err_out;

    int n_tests = 0;
    int n_fail  = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(TO), .TO_CNT_W(8)) dut (
        .clk_in(clk_in), .reset_in(reset_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .addr_in(addr_in), .wr_en_in(wr_en_in), .byte_en_in(byte_en_in),
        .signed_in(signed_in), .wdata_in(wdata_in),
        .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
        .mem_addr_out(mem_addr_out), .mem_be_out(mem_be_out),
        .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in),
        .mem_ack_in(mem_ack_in), .done_out(done_out),
        .rd_valid_out(rd_valid_out), .rd_data_out(rd_data_out),
        .busy_out(busy_out), .timeout_err_out(timeout_err_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: expected bus lanes and load value from byte-level rules
    function automatic logic [3:0] m_be(input logic we, input logic bt, input logic [31:0] a);
        if (!we || !bt) return 4'hF;
        case (a % 4)
            0: return 4'h1;
            1: return 4'h2;
            2: return 4'h4;
            default: return 4'h8;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic we, input logic bt, input logic [31:0] d);
        logic [31:0] low;
        low = d & 32'hFF;
        if (!we) return 32'h0;
        if (bt) return low * 32'h01010101;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic bt, input logic sg, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [7:0]  b [4];
        logic [31:0] r;
        int          off;
        off = int'(a % 4);
        for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
        if (bt) begin
            r = 32'(b[off]);
            if (sg && b[off] >= 8'd128) r = r | 32'hFFFFFF00;
        end else begin
            r = 0;
            for (int j = 0; j < 4; j++) r[8*j +: 8] = b[(j + off) % 4];
        end
        return r;
    endfunction

    // One full transaction: accept, REQ with waits (>= TO means never ack), RESP, stray ack afterwards
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic bt, input logic sg,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                           input logic [31:0] e_addr, input logic [3:0] e_be,
                           input logic [31:0] e_wdata, input logic [31:0] e_rd,
                           input logic e_abort);
        bit fin = 0;
        chk("ready_before", 32'(req_ready_out), 32'd1);
        req_valid_in = 1'b1; addr_in = addr; wr_en_in = we; byte_en_in = bt;
        signed_in = sg; wdata_in = wdata;
        tick();
        req_valid_in = 1'b0;
        chk("req_first", 32'(mem_req_out), 32'd1);
        chk("busy_first", 32'(busy_out), 32'd1);
        chk("we", 32'(mem_we_out), 32'(we));
        chk("addr", mem_addr_out, e_addr);
        chk("be", 32'(mem_be_out), 32'(e_be));
        chk("wdata", mem_wdata_out, e_wdata);
        for (int c = 0; c < 8 && !fin; c++) begin
            mem_ack_in   = (c == waits);
            mem_rdata_in = (c == waits) ? rdata : $urandom;
            req_valid_in = 1'($urandom_range(0, 1));
            addr_in      = $urandom;
            tick();
            mem_ack_in = 1'b0;
            if (c == waits || c == int'(TO) - 1) begin
                fin = 1;
                req_valid_in = 1'b0;
                chk("done", 32'(done_out), 32'd1);
                chk("rd_valid", 32'(rd_valid_out), 32'(!we && !e_abort));
                chk("timeout_err", 32'(timeout_err_out), 32'(e_abort));
                chk("rd_data", rd_data_out, e_rd);
                chk("req_low_resp", 32'(mem_req_out), 32'd0);
                chk("ready_resp", 32'(req_ready_out), 32'd0);
            end else begin
                chk("req_held", 32'(mem_req_out), 32'd1);
                chk("done_early", 32'(done_out), 32'd0);
                chk("addr_stable", mem_addr_out, e_addr);
                chk("be_stable", 32'(mem_be_out), 32'(e_be));
                chk("wdata_stable", mem_wdata_out, e_wdata);
            end
        end
        mem_ack_in   = 1'b1;
        mem_rdata_in = $urandom;
        tick();
        chk("ready_after", 32'(req_ready_out), 32'd1);
        chk("done_after", 32'(done_out), 32'd0);
        chk("err_after", 32'(timeout_err_out), 32'd0);
        tick();
        mem_ack_in = 1'b0;
        chk("stray_ack_idle", 32'(mem_req_out), 32'd0);
        chk("stray_ack_done", 32'(done_out), 32'd0);
        chk("rd_data_held", rd_data_out, e_rd);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic        bt;
        logic        sg;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_rd;
        logic        e_abort;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] exp_rd;

    initial begin
        // addr, we, bt, sg, wdata, rdata, waits, e_addr, e_be, e_wdata, e_rd, e_abort
        vecs[0] = '{32'h104, 1, 0, 0, 32'hDEADBEEF, 32'h0, 0, 32'h104, 4'hF, 32'hDEADBEEF, 32'h0, 0};
        vecs[1] = '{32'h203, 1, 1, 0, 32'h000000A5, 32'h0, 3, 32'h200, 4'h8, 32'hA5A5A5A5, 32'h0, 0};
        vecs[2] = '{32'h102, 0, 0, 0, 32'h0, 32'h11223344, 1, 32'h100, 4'hF, 32'h0, 32'h33441122, 0};
        vecs[3] = '{32'h301, 0, 1, 1, 32'h0, 32'h00008000, 0, 32'h300, 4'hF, 32'h0, 32'hFFFFFF80, 0};
        vecs[4] = '{32'h301, 0, 1, 0, 32'h0, 32'h00008000, 2, 32'h300, 4'hF, 32'h0, 32'h00000080, 0};
        vecs[5] = '{32'h100, 0, 0, 0, 32'h0, 32'hCAFEF00D, 9, 32'h100, 4'hF, 32'h0, 32'h00000080, 1};
        vecs[6] = '{32'h302, 0, 1, 0, 32'h0, 32'h00AB0000, 3, 32'h300, 4'hF, 32'h0, 32'h000000AB, 0};
        vecs[7] = '{32'h010, 1, 0, 0, 32'h12345678, 32'h0, 9, 32'h010, 4'hF, 32'h12345678, 32'h000000AB, 1};
        vecs[8] = '{32'h003, 0, 0, 0, 32'h0, 32'hAABBCCDD, 0, 32'h000, 4'hF, 32'h0, 32'hBBCCDDAA, 0};

        reset_in = 1'b0; req_valid_in = 1'b0; addr_in = '0; wr_en_in = 1'b0;
        byte_en_in = 1'b0; signed_in = 1'b0; wdata_in = '0;
        mem_rdata_in = '0; mem_ack_in = 1'b0;
        tick(); tick();
        chk("rst_ready", 32'(req_ready_out), 32'd1);
        chk("rst_busy", 32'(busy_out), 32'd0);
        chk("rst_req", 32'(mem_req_out), 32'd0);
        chk("rst_done", 32'(done_out), 32'd0);
        chk("rst_rd_data", rd_data_out, 32'd0);
        chk("rst_err", 32'(timeout_err_out), 32'd0);
        reset_in = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].addr, vecs[i].we, vecs[i].bt, vecs[i].sg, vecs[i].wdata,
                    vecs[i].rdata, vecs[i].waits, vecs[i].e_addr, vecs[i].e_be,
                    vecs[i].e_wdata, vecs[i].e_rd, vecs[i].e_abort);
        end

        // Reset while waiting for ack: request drops, no completion, then a clean load
        req_valid_in = 1'b1; addr_in = 32'h40; wr_en_in = 1'b0; byte_en_in = 1'b0;
        tick();
        req_valid_in = 1'b0;
        chk("rstmid_req", 32'(mem_req_out), 32'd1);
        tick(); tick();
        reset_in = 1'b0;
        tick();
        chk("rstmid_req_low", 32'(mem_req_out), 32'd0);
        chk("rstmid_done", 32'(done_out), 32'd0);
        chk("rstmid_ready", 32'(req_ready_out), 32'd1);
        reset_in = 1'b1;
        tick();
        chk("rstmid_done2", 32'(done_out), 32'd0);
        chk("rstmid_err", 32'(timeout_err_out), 32'd0);
        run_txn(32'h44, 0, 0, 0, 32'h0, 32'h12345678, 1, 32'h44, 4'hF, 32'h0, 32'h12345678, 0);
        exp_rd = 32'h12345678;

        // Randomized transactions against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, wd, rd;
            logic        we, bt, sg, ab;
            int          w;
            a  = $urandom; wd = $urandom; rd = $urandom;
            we = 1'($urandom_range(0, 1));
            bt = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            w  = $urandom_range(0, 5);
            ab = (w >= int'(TO));
            if (!we && !ab) exp_rd = m_load(bt, sg, a, rd);
            run_txn(a, we, bt, sg, wd, rd, w, a & 32'hFFFFFFFC, m_be(we, bt, a),
                    m_wdata(we, bt, wd), exp_rd, ab);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
